// File: rtl/fifo_sync_buf.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_buf
// Description : Single-clock parametrised FIFO. Word RAM with pointer/count
//               control, registered status flags (full, empty, almost-full,
//               almost-empty), synchronous flush and sticky overflow /
//               underflow error flags.
//               Optional feature macro: FIFO_SYNC_BUF_PARITY_EN
//                 When defined, an even-parity bit is stored with each word.
//                 A sticky parity_err_o port reports a mismatch found on
//                 any accepted read.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i          in   1          clock, rising edge
//   rstn_i         in   1          synchronous active-low reset
//   flush_i        in   1          synchronous clear of pointers and count
//   wen_i          in   1          write request
//   wdata_i        in   WIDTH      write data
//   ren_i          in   1          read request
//   rdata_o        out  WIDTH      registered read data
//   rvalid_o       out  1          one-cycle pulse: rdata_o updated
//   full_o         out  1          count == FIFO_DEPTH
//   empty_o        out  1          count == 0
//   almost_full_o  out  1          count >= AF_LEVEL
//   almost_empty_o out  1          count <= AE_LEVEL
//   count_o        out  A_WIDTH+1  fill level 0..FIFO_DEPTH
//   overflow_o     out  1          sticky: write attempted while full
//   underflow_o    out  1          sticky: read attempted while empty
//   err_clr_i      in   1          clears sticky error flags
//   parity_err_o   out  1          sticky parity error (parity build only)
// ============================================================================
module fifo_sync_buf #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                              clk_i,
    input  logic                              rstn_i,
    input  logic                              flush_i,
    input  logic                              wen_i,
    input  logic [WIDTH-1:0]                  wdata_i,
    input  logic                              ren_i,
    output logic [WIDTH-1:0]                  rdata_o,
    output logic                              rvalid_o,
    output logic                              full_o,
    output logic                              empty_o,
    output logic                              almost_full_o,
    output logic                              almost_empty_o,
    output logic [$clog2(FIFO_DEPTH):0]       count_o,
    output logic                              overflow_o,
    output logic                              underflow_o,
    input  logic                              err_clr_i
`ifdef FIFO_SYNC_BUF_PARITY_EN
    ,
    output logic                              parity_err_o
`endif
);

    // Pointer width is derived from the depth and must not be overridden.
    localparam int A_WIDTH = $clog2(FIFO_DEPTH);

`ifdef FIFO_SYNC_BUF_PARITY_EN
    localparam int RAM_W = WIDTH + 1;
`else
    localparam int RAM_W = WIDTH;
`endif

    localparam logic [A_WIDTH:0]   CNT_ONE   = (A_WIDTH+1)'(1);
    localparam logic [A_WIDTH:0]   CNT_DEPTH = (A_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [A_WIDTH:0]   CNT_AF    = (A_WIDTH+1)'(AF_LEVEL);
    localparam logic [A_WIDTH:0]   CNT_AE    = (A_WIDTH+1)'(AE_LEVEL);
    localparam logic [A_WIDTH-1:0] PTR_ONE   = A_WIDTH'(1);

    logic [RAM_W-1:0]   mem [FIFO_DEPTH];
    logic [A_WIDTH-1:0] wptr;
    logic [A_WIDTH-1:0] rptr;
    logic [A_WIDTH:0]   count_nxt;
    logic               wr_acc;
    logic               rd_acc;
    logic               ovf_set;
    logic               udf_set;
    logic [RAM_W-1:0]   wr_word;

    // Accepts are qualified by the registered full/empty flags, so a full
    // FIFO with both requests reads and rejects the write, and an empty FIFO
    // with both requests writes and rejects the read.
    always_comb begin
        wr_acc  = rstn_i && !flush_i && wen_i && !full_o;
        rd_acc  = rstn_i && !flush_i && ren_i && !empty_o;
        ovf_set = wen_i && full_o  && !flush_i;
        udf_set = ren_i && empty_o && !flush_i;
    end

    always_comb begin
        count_nxt = count_o;
        if (flush_i) begin
            count_nxt = '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count_nxt = count_o + CNT_ONE;
                2'b01:   count_nxt = count_o - CNT_ONE;
                default: count_nxt = count_o;
            endcase
        end
    end

`ifdef FIFO_SYNC_BUF_PARITY_EN
    // Even parity: stored bit equals XOR of data, so a healthy word XORs to 0.
    assign wr_word = {^wdata_i, wdata_i};
`else
    assign wr_word = wdata_i;
`endif

    // RAM is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wptr] <= wr_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wptr           <= '0;
            rptr           <= '0;
            count_o        <= '0;
            full_o         <= 1'b0;
            empty_o        <= 1'b1;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
            rdata_o        <= '0;
            rvalid_o       <= 1'b0;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
        end else begin
            rvalid_o <= rd_acc;
            if (rd_acc) begin
                rdata_o <= mem[rptr][WIDTH-1:0];
            end

            if (flush_i) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_acc) wptr <= wptr + PTR_ONE;
                if (rd_acc) rptr <= rptr + PTR_ONE;
            end

            // Flags come from the next count so they line up with count_o.
            count_o        <= count_nxt;
            full_o         <= (count_nxt == CNT_DEPTH);
            empty_o        <= (count_nxt == '0);
            almost_full_o  <= (count_nxt >= CNT_AF);
            almost_empty_o <= (count_nxt <= CNT_AE);

            // Set wins over a simultaneous clear.
            overflow_o  <= ovf_set | (overflow_o  & ~err_clr_i);
            underflow_o <= udf_set | (underflow_o & ~err_clr_i);
        end
    end

`ifdef FIFO_SYNC_BUF_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            parity_err_o <= 1'b0;
        end else begin
            parity_err_o <= (rd_acc && (^mem[rptr])) | (parity_err_o & ~err_clr_i);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_buf
// Description : Self-checking bench for fifo_sync_buf. A queue-based model
//               tracks contents, read data and sticky flags; scenario tasks
//               compare DUT outputs against constants or the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_buf;

    localparam int W  = 32;
    localparam int D  = 16;
    localparam int AF = 14;
    localparam int AE = 2;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         flush = 1'b0;
    logic         wen = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         ren = 1'b0;
    logic         err_clr = 1'b0;
    logic [W-1:0] rdata;
    logic         rvalid, full, empty, afull, aempty, ovf, udf;
    logic [4:0]   count;
`ifdef FIFO_SYNC_BUF_PARITY_EN
    logic         perr;
`endif

    always #5 clk = ~clk;

    fifo_sync_buf #(
        .WIDTH(W), .FIFO_DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .wen_i(wen),
        .wdata_i(wdata), .ren_i(ren), .rdata_o(rdata), .rvalid_o(rvalid),
        .full_o(full), .empty_o(empty), .almost_full_o(afull),
        .almost_empty_o(aempty), .count_o(count), .overflow_o(ovf),
        .underflow_o(udf), .err_clr_i(err_clr)
`ifdef FIFO_SYNC_BUF_PARITY_EN
        , .parity_err_o(perr)
`endif
    );

    // Reference model
    logic [W-1:0] mq[$];
    logic [W-1:0] m_rdata = '0;
    bit           m_rvalid = 0;
    bit           m_ovf = 0;
    bit           m_udf = 0;

    int n_tests = 0;
    int n_fail  = 0;

    // Drive one clock cycle and advance the model; outputs are stable 1ns
    // after the edge when this returns.
    task automatic cycle(input bit w, input logic [W-1:0] wd, input bit r,
                         input bit fl, input bit clr, input bit rn);
        int  sz;
        bit  mfull, mempty, oset, uset;
        wen = w; wdata = wd; ren = r; flush = fl; err_clr = clr; rstn = rn;
        @(posedge clk);
        sz = mq.size(); mfull = (sz == D); mempty = (sz == 0);
        if (!rn) begin
            mq.delete(); m_rdata = '0; m_rvalid = 0; m_ovf = 0; m_udf = 0;
        end else if (fl) begin
            mq.delete(); m_rvalid = 0;
            if (clr) begin m_ovf = 0; m_udf = 0; end
        end else begin
            oset = w && mfull; uset = r && mempty;
            m_rvalid = 0;
            if (r && !mempty) begin m_rdata = mq.pop_front(); m_rvalid = 1; end
            if (w && !mfull) mq.push_back(wd);
            m_ovf = oset | (m_ovf & !clr);
            m_udf = uset | (m_udf & !clr);
        end
        #1;
        wen = 0; ren = 0; flush = 0; err_clr = 0;
    endtask

    task automatic test_reset();
        cycle(0, '0, 0, 0, 0, 0);
        cycle(0, '0, 0, 0, 0, 0);
        repeat (3) cycle(0, '0, 0, 0, 0, 1);
        n_tests++; if (empty !== 1'b1)  begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_tests++; if (aempty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty: got %b want 1", aempty); end
        n_tests++; if (count !== 5'd0)  begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_tests++; if (rdata !== '0)    begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
        n_tests++; if (full !== 1'b0 || afull !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b%b want 00", full, afull); end
        n_tests++; if (ovf !== 1'b0 || udf !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %b%b want 00", ovf, udf); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < D; i++) begin
            cycle(1, W'(i), 0, 0, 0, 1);
            n_tests++; if (count !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i + 1); end
            n_tests++; if (afull !== (i + 1 >= AF)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b want %b", i, afull, (i + 1 >= AF)); end
            n_tests++; if (full !== (i == D - 1)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == D - 1)); end
            n_tests++; if (aempty !== (i + 1 <= AE)) begin n_fail++; $display("FAIL fill_aempty[%0d]: got %b want %b", i, aempty, (i + 1 <= AE)); end
        end
        for (int i = 0; i < D; i++) begin
            cycle(0, '0, 1, 0, 0, 1);
            n_tests++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL drain_rvalid[%0d]: got %b want 1", i, rvalid); end
            n_tests++; if (rdata !== W'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, rdata, W'(i)); end
            n_tests++; if (count !== 5'(D - 1 - i)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, D - 1 - i); end
        end
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
        cycle(0, '0, 0, 0, 0, 1);
        n_tests++; if (rvalid !== 1'b0 || rdata !== W'(D - 1)) begin n_fail++; $display("FAIL drain_hold: got %b/%h want 0/%h", rvalid, rdata, W'(D - 1)); end
    endtask

    task automatic test_overflow();
        logic [W-1:0] exp;
        for (int i = 0; i < D; i++) cycle(1, W'(32'h100 + i), 0, 0, 0, 1);
        cycle(1, W'(32'hAA), 1, 0, 0, 1);
        n_tests++; if (rvalid !== 1'b1 || rdata !== W'(32'h100)) begin n_fail++; $display("FAIL ovf_read: got %b/%h want 1/100", rvalid, rdata); end
        n_tests++; if (count !== 5'd15) begin n_fail++; $display("FAIL ovf_count: got %0d want 15", count); end
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        cycle(1, W'(32'h200), 0, 0, 0, 1);
        n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_refull: got %b want 1", full); end
        cycle(1, W'(32'hBB), 0, 0, 1, 1);
        n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_setwins: got %b want 1", ovf); end
        cycle(0, '0, 0, 0, 1, 1);
        n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", ovf); end
        for (int i = 0; i < D; i++) begin
            cycle(0, '0, 1, 0, 0, 1);
            exp = (i < D - 1) ? W'(32'h101 + i) : W'(32'h200);
            n_tests++; if (rdata !== exp) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, rdata, exp); end
        end
    endtask

    task automatic test_underflow();
        cycle(1, W'(32'h55), 1, 0, 0, 1);
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL udf_rvalid: got %b want 0", rvalid); end
        n_tests++; if (udf !== 1'b1 || ovf !== 1'b0) begin n_fail++; $display("FAIL udf_flag: got %b%b want 10", udf, ovf); end
        n_tests++; if (count !== 5'd1) begin n_fail++; $display("FAIL udf_count: got %0d want 1", count); end
        cycle(0, '0, 1, 0, 0, 1);
        n_tests++; if (rvalid !== 1'b1 || rdata !== W'(32'h55)) begin n_fail++; $display("FAIL udf_read: got %b/%h want 1/55", rvalid, rdata); end
        cycle(0, '0, 0, 0, 1, 1);
        n_tests++; if (udf !== 1'b0) begin n_fail++; $display("FAIL udf_clear: got %b want 0", udf); end
    endtask

    task automatic test_wrap_flush();
        int wv = 32'h300;
        int rv = 32'h300;
        for (int k = 0; k < 3; k++) begin
            repeat (5) begin cycle(1, W'(wv), 0, 0, 0, 1); wv++; end
            cycle(1, W'(wv), 1, 0, 0, 1); wv++;
            n_tests++; if (count !== 5'd5) begin n_fail++; $display("FAIL wrap_steady[%0d]: got %0d want 5", k, count); end
            n_tests++; if (rdata !== W'(rv)) begin n_fail++; $display("FAIL wrap_both[%0d]: got %h want %h", k, rdata, W'(rv)); end
            rv++;
            repeat (4) begin cycle(1, W'(wv), 0, 0, 0, 1); wv++; end
            repeat (9) begin
                cycle(0, '0, 1, 0, 0, 1);
                n_tests++; if (rdata !== W'(rv) || rvalid !== 1'b1) begin n_fail++; $display("FAIL wrap_data: got %b/%h want 1/%h", rvalid, rdata, W'(rv)); end
                rv++;
            end
        end
        cycle(0, '0, 1, 0, 0, 1);
        for (int i = 0; i < 7; i++) cycle(1, W'(i), 0, 0, 0, 1);
        n_tests++; if (count !== 5'd7) begin n_fail++; $display("FAIL flush_pre: got %0d want 7", count); end
        cycle(1, W'(32'hEE), 1, 1, 0, 1);
        n_tests++; if (count !== 5'd0 || empty !== 1'b1 || aempty !== 1'b1) begin n_fail++; $display("FAIL flush_state: got %0d/%b/%b want 0/1/1", count, empty, aempty); end
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL flush_rvalid: got %b want 0", rvalid); end
        n_tests++; if (udf !== 1'b1 || ovf !== 1'b0) begin n_fail++; $display("FAIL flush_sticky: got %b%b want 10", udf, ovf); end
        cycle(0, '0, 0, 0, 1, 1);
    endtask

`ifdef FIFO_SYNC_BUF_PARITY_EN
    task automatic test_parity();
        logic p;
        cycle(0, '0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, W'(32'h1000 + i), 0, 0, 0, 1);
        p = dut.mem[3][W];
        force dut.mem[3][W] = ~p;
        for (int i = 0; i < 4; i++) begin
            cycle(0, '0, 1, 0, 0, 1);
            n_tests++; if (perr !== (i == 3)) begin n_fail++; $display("FAIL parity_rd[%0d]: got %b want %b", i, perr, (i == 3)); end
        end
        release dut.mem[3][W];
        cycle(0, '0, 0, 0, 0, 1);
        n_tests++; if (perr !== 1'b1) begin n_fail++; $display("FAIL parity_hold: got %b want 1", perr); end
        cycle(0, '0, 0, 0, 1, 1);
        n_tests++; if (perr !== 1'b0) begin n_fail++; $display("FAIL parity_clear: got %b want 0", perr); end
    endtask
`endif

    task automatic test_random();
        bit w, r, fl, clr, rn;
        int pw, pr, sz;
        for (int c = 0; c < 1200; c++) begin
            pw = ((c / 150) % 2 == 0) ? 75 : 30;
            pr = ((c / 150) % 2 == 0) ? 30 : 75;
            w   = ($urandom_range(99) < pw);
            r   = ($urandom_range(99) < pr);
            fl  = ($urandom_range(99) < 2);
            clr = ($urandom_range(99) < 4);
            rn  = ($urandom_range(199) != 0);
            cycle(w, W'($urandom), r, fl, clr, rn);
            sz = mq.size();
            n_tests++;
            if (count !== 5'(sz) || full !== (sz == D) || empty !== (sz == 0) ||
                afull !== (sz >= AF) || aempty !== (sz <= AE) ||
                rvalid !== m_rvalid || rdata !== m_rdata ||
                ovf !== m_ovf || udf !== m_udf) begin
                n_fail++;
                $display("FAIL rand[%0d]: got cnt=%0d f=%b e=%b af=%b ae=%b v=%b d=%h o=%b u=%b want cnt=%0d f=%b e=%b af=%b ae=%b v=%b d=%h o=%b u=%b",
                         c, count, full, empty, afull, aempty, rvalid, rdata, ovf, udf,
                         sz, (sz == D), (sz == 0), (sz >= AF), (sz <= AE), m_rvalid, m_rdata, m_ovf, m_udf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_wrap_flush();
`ifdef FIFO_SYNC_BUF_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
